// File: rtl/lab1_imul_int_mul_nbits_if.sv
// Request/response bundle for the iterative nbits multiplier.
// Both channels use valid/ready: a transfer happens on a rising clock edge where
// valid and ready are both high. The sender holds the message stable while valid is high.
interface lab1_imul_int_mul_nbits_if #(
  parameter int nbits = 32
);
  logic               req_val;
  logic               req_rdy;
  logic [2*nbits:0]   req_msg;
  logic               resp_val;
  logic               resp_rdy;
  logic [2*nbits-1:0] resp_msg;

  modport master (
    output req_val, req_msg, resp_rdy,
    input  req_rdy, resp_val, resp_msg
  );

  modport slave (
    input  req_val, req_msg, resp_rdy,
    output req_rdy, resp_val, resp_msg
  );
endinterface

// File: rtl/lab1_imul_int_mul_nbits.sv
// Variable-latency shift-and-add multiplier returning the full 2*nbits product.
// Signed requests multiply magnitudes and re-apply the sign when the product is complete.
module lab1_imul_int_mul_nbits #(
  parameter int nbits = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  lab1_imul_int_mul_nbits_if.slave      bus,
  output logic [1:0]                    state_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q;
  logic [2*nbits-1:0] a_q;
  logic [nbits-1:0]   b_q;
  logic [2*nbits-1:0] result_q;
  logic               neg_q;
  logic               req_rdy_q;
  logic               resp_val_q;
  logic [2*nbits-1:0] resp_msg_q;

  logic               sgn_d;
  logic [nbits-1:0]   a_in_d;
  logic [nbits-1:0]   b_in_d;
  logic [nbits-1:0]   a_abs_d;
  logic [nbits-1:0]   b_abs_d;
  logic [2*nbits-1:0] sum_d;
  logic [nbits-1:0]   b_shift_d;
  logic [2*nbits-1:0] prod_d;

  always_comb begin
    sgn_d     = bus.req_msg[2*nbits];
    a_in_d    = bus.req_msg[2*nbits-1:nbits];
    b_in_d    = bus.req_msg[nbits-1:0];
    // Negating the most negative value yields 2^(nbits-1), which is correct read as unsigned.
    a_abs_d   = (sgn_d && a_in_d[nbits-1]) ? -a_in_d : a_in_d;
    b_abs_d   = (sgn_d && b_in_d[nbits-1]) ? -b_in_d : b_in_d;
    sum_d     = b_q[0] ? (result_q + a_q) : result_q;
    b_shift_d = b_q >> 1;
    prod_d    = neg_q ? -sum_d : sum_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      neg_q      <= 1'b0;
      req_rdy_q  <= 1'b0;
      resp_val_q <= 1'b0;
      resp_msg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_rdy_q && bus.req_val) begin
            a_q       <= {{nbits{1'b0}}, a_abs_d};
            b_q       <= b_abs_d;
            result_q  <= '0;
            neg_q     <= sgn_d & (a_in_d[nbits-1] ^ b_in_d[nbits-1]);
            req_rdy_q <= 1'b0;
            state_q   <= CALC;
          end else begin
            req_rdy_q <= 1'b1;
          end
        end
        CALC: begin
          result_q <= sum_d;
          a_q      <= a_q << 1;
          b_q      <= b_shift_d;
          // The final step's sum goes straight to the response register.
          if (b_shift_d == '0) begin
            resp_val_q <= 1'b1;
            resp_msg_q <= prod_d;
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (bus.resp_rdy) begin
            resp_val_q <= 1'b0;
            req_rdy_q  <= 1'b1;
            state_q    <= IDLE;
          end
        end
        default: begin
          resp_val_q <= 1'b0;
          req_rdy_q  <= 1'b1;
          state_q    <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_rdy  = req_rdy_q;
  assign bus.resp_val = resp_val_q;
  assign bus.resp_msg = resp_msg_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_lab1_imul_int_mul_nbits.sv
// Bench for the iterative multiplier: directed and random 32-bit cases, backpressure,
// reset abort, and a stalled random sweep on an 8-bit instance.
module tb_lab1_imul_int_mul_nbits;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  lab1_imul_int_mul_nbits_if #(.nbits(32)) if32 ();
  lab1_imul_int_mul_nbits_if #(.nbits(8))  if8 ();
  logic [1:0] st32;
  logic [1:0] st8;

  lab1_imul_int_mul_nbits #(.nbits(32)) dut32 (
    .clk(clk), .reset(rst), .bus(if32), .state_o(st32)
  );
  lab1_imul_int_mul_nbits #(.nbits(8)) dut8 (
    .clk(clk), .reset(rst), .bus(if8), .state_o(st8)
  );

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          lat_q[$];

  // Reference: integer product of the operands read as n-bit signed or unsigned values.
  function automatic logic [63:0] ref_prod(input int n, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, p;
    sa = longint'(a);
    sb = longint'(b);
    if (sgn && a[n-1]) sa = sa - (longint'(1) << n);
    if (sgn && b[n-1]) sb = sb - (longint'(1) << n);
    p = sa * sb;
    if (n < 32) p = p & ((longint'(1) << (2*n)) - 1);
    return 64'(p);
  endfunction

  // Reference latency: one cycle past the CALC count, which is the position of the top set bit of |B|.
  function automatic int ref_lat(input int n, input bit sgn, input logic [31:0] b);
    longint mag;
    int k;
    mag = longint'(b);
    if (sgn && b[n-1]) mag = (longint'(1) << n) - mag;
    k = 1;
    for (int i = 0; i < n; i++) if (mag[i]) k = i + 1;
    return k + 1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives one 32-bit transaction with resp_rdy high; lat is -1 if no response arrives.
  task automatic drive32(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] res, output int lat);
    int n;
    n = 0;
    while (!if32.req_rdy && n < 100) begin tick(); n++; end
    if32.req_msg  = {sgn, a, b};
    if32.req_val  = 1'b1;
    if32.resp_rdy = 1'b1;
    tick();
    if32.req_val = 1'b0;
    if32.req_msg = 65'({$urandom(), $urandom(), $urandom()});
    n = 1;
    while (!if32.resp_val && n < 100) begin tick(); n++; end
    res = if32.resp_msg;
    lat = if32.resp_val ? n : -1;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    checks++;
    if ({if32.req_rdy, if32.resp_val, if32.resp_msg} !== 66'd0) begin
      errors++;
      $display("FAIL reset32_outputs: got rdy=%0b val=%0b msg=%h, want all zero",
               if32.req_rdy, if32.resp_val, if32.resp_msg);
    end
    checks++;
    if ({if8.req_rdy, if8.resp_val, if8.resp_msg} !== 18'd0) begin
      errors++;
      $display("FAIL reset8_outputs: got rdy=%0b val=%0b msg=%h, want all zero",
               if8.req_rdy, if8.resp_val, if8.resp_msg);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (if32.req_rdy !== 1'b1 || if8.req_rdy !== 1'b1 || if32.resp_val !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy32=%0b rdy8=%0b val32=%0b, want 1 1 0",
               if32.req_rdy, if8.req_rdy, if32.resp_val);
    end
  endtask

  task automatic test_directed();
    bit          sgn_t[6] = '{0, 0, 1, 1, 0, 1};
    logic [31:0] a_t[6]   = '{32'd3, 32'hDEADBEEF, 32'hFFFFFFFD, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b_t[6]   = '{32'd4, 32'd0, 32'd5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [63:0] p_t[6]   = '{64'hC, 64'h0, 64'hFFFFFFFFFFFFFFF1, 64'h4000000000000000,
                              64'hFFFFFFFE00000001, 64'h1};
    int          l_t[6]   = '{4, 2, 4, 33, 33, 2};
    logic [63:0] res;
    int          lat;
    for (int i = 0; i < 6; i++) begin
      drive32(sgn_t[i], a_t[i], b_t[i], res, lat);
      checks++;
      if (res !== p_t[i]) begin
        errors++;
        $display("FAIL directed_prod[%0d]: got %h, want %h", i, res, p_t[i]);
      end
      checks++;
      if (lat != l_t[i]) begin
        errors++;
        $display("FAIL directed_lat[%0d]: got %0d, want %0d", i, lat, l_t[i]);
      end
      checks++;
      if (if32.req_rdy !== 1'b1 || if32.resp_val !== 1'b0) begin
        errors++;
        $display("FAIL directed_return_idle[%0d]: got rdy=%0b val=%0b, want 1 0",
                 i, if32.req_rdy, if32.resp_val);
      end
    end
  endtask

  task automatic test_random32();
    logic [63:0] res, exp;
    logic [31:0] a, b;
    bit          sgn;
    int          lat, elat;
    for (int i = 0; i < 24; i++) begin
      sgn  = 1'($urandom_range(0, 1));
      a    = $urandom();
      b    = $urandom() >> $urandom_range(0, 31);
      exp  = ref_prod(32, sgn, a, b);
      elat = ref_lat(32, sgn, b);
      drive32(sgn, a, b, res, lat);
      checks++;
      if (res !== exp || lat != elat) begin
        errors++;
        $display("FAIL random32[%0d]: got prod=%h lat=%0d, want prod=%h lat=%0d (s=%0b a=%h b=%h)",
                 i, res, lat, exp, elat, sgn, a, b);
      end
    end
  endtask

  task automatic test_backpressure_reset();
    int n, bad, seen;
    if32.req_msg  = {1'b0, 32'd7, 32'd9};
    if32.req_val  = 1'b1;
    if32.resp_rdy = 1'b0;
    tick();
    if32.req_val = 1'b0;
    n = 1;
    while (!if32.resp_val && n < 100) begin tick(); n++; end
    checks++;
    if (if32.resp_val !== 1'b1 || n != 5) begin
      errors++;
      $display("FAIL bp_latency: got val=%0b after %0d cycles, want 1 after 5", if32.resp_val, n);
    end
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (if32.resp_val !== 1'b1 || if32.req_rdy !== 1'b0 || if32.resp_msg !== 64'd63) bad++;
      tick();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL bp_hold: got %0d unstable cycles (msg=%h), want 0 with msg=3f", bad, if32.resp_msg);
    end
    if32.resp_rdy = 1'b1;
    tick();
    checks++;
    if (if32.req_rdy !== 1'b1 || if32.resp_val !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got rdy=%0b val=%0b, want 1 0", if32.req_rdy, if32.resp_val);
    end
    if32.req_msg = {1'b0, 32'h12345678, 32'hFFFFFFFF};
    if32.req_val = 1'b1;
    tick();
    if32.req_val = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    checks++;
    if ({if32.req_rdy, if32.resp_val, if32.resp_msg} !== 66'd0) begin
      errors++;
      $display("FAIL abort_reset_cycle: got rdy=%0b val=%0b msg=%h, want all zero",
               if32.req_rdy, if32.resp_val, if32.resp_msg);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (if32.req_rdy !== 1'b1) begin
      errors++;
      $display("FAIL abort_idle: got rdy=%0b, want 1", if32.req_rdy);
    end
    seen = 0;
    for (int i = 0; i < 45; i++) begin
      if (if32.resp_val !== 1'b0) seen++;
      tick();
    end
    checks++;
    if (seen != 0) begin
      errors++;
      $display("FAIL abort_no_resp: got %0d cycles with resp_val, want 0", seen);
    end
  endtask

  task automatic test_sweep8();
    logic [63:0] p;
    logic [15:0] exp, held;
    logic [7:0]  a, b;
    bit          sgn;
    int          n, elat, bad;
    for (int i = 0; i < 200; i++) begin
      sgn = 1'($urandom_range(0, 1));
      a   = 8'($urandom_range(0, 255));
      b   = 8'($urandom_range(0, 255) >> $urandom_range(0, 7));
      repeat ($urandom_range(0, 3)) tick();
      n = 0;
      while (!if8.req_rdy && n < 50) begin tick(); n++; end
      if8.req_msg  = {sgn, a, b};
      if8.req_val  = 1'b1;
      if8.resp_rdy = 1'b0;
      tick();
      if8.req_val = 1'b0;
      if8.req_msg = 17'($urandom());
      p = ref_prod(8, sgn, {24'd0, a}, {24'd0, b});
      exp_q.push_back(p[15:0]);
      lat_q.push_back(ref_lat(8, sgn, {24'd0, b}));
      n = 1;
      while (!if8.resp_val && n < 50) begin tick(); n++; end
      exp  = exp_q.pop_front();
      elat = lat_q.pop_front();
      checks++;
      if (if8.resp_val !== 1'b1 || if8.resp_msg !== exp || n != elat) begin
        errors++;
        $display("FAIL sweep8[%0d]: got val=%0b prod=%h lat=%0d, want prod=%h lat=%0d (s=%0b a=%h b=%h)",
                 i, if8.resp_val, if8.resp_msg, n, exp, elat, sgn, a, b);
      end
      held = if8.resp_msg;
      bad  = 0;
      repeat ($urandom_range(0, 3)) begin
        tick();
        if (if8.resp_val !== 1'b1 || if8.resp_msg !== held || if8.req_rdy !== 1'b0) bad++;
      end
      if8.resp_rdy = 1'b1;
      tick();
      if8.resp_rdy = 1'b0;
      checks++;
      if (bad != 0 || if8.req_rdy !== 1'b1 || if8.resp_val !== 1'b0) begin
        errors++;
        $display("FAIL sweep8_stall[%0d]: got bad=%0d rdy=%0b val=%0b, want 0 1 0",
                 i, bad, if8.req_rdy, if8.resp_val);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    if32.req_val  = 1'b0;
    if32.req_msg  = '0;
    if32.resp_rdy = 1'b0;
    if8.req_val   = 1'b0;
    if8.req_msg   = '0;
    if8.resp_rdy  = 1'b0;
    test_reset();
    test_directed();
    test_random32();
    test_backpressure_reset();
    test_sweep8();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab1_imul_int_mul_nbits.md
# lab1_imul_int_mul_nbits

Parametrised, variable-latency iterative integer multiplier with a full-width product and a per-request signed/unsigned mode. It sits behind the same val/rdy request/response interfaces as the lab1 multipliers and extends them in three ways: operand width is a parameter, the full 2×nbits product is returned, and signed operands are supported. Latency depends on the magnitude of operand B. Iteration stops as soon as the remaining multiplier bits are zero.

## Interface
- `nbits`, default 32: operand width; legal range ≥ 2.
- `clk` input, 1 bit: clock.
- `reset` input, 1 bit: synchronous, active-high reset.
- `req_val` input, 1 bit: request valid.
- `req_rdy` output, 1 bit: request ready.
- `req_msg` input, 2*nbits+1 bits:
  - [2*nbits] = signed flag (1 = two's-complement operands);
  - [2*nbits-1:nbits] = A;
  - [nbits-1:0] = B.
- `resp_val` output, 1 bit: response valid.
- `resp_rdy` input, 1 bit: response ready.
- `resp_msg` output, 2*nbits bits: full product A×B. Signed or unsigned interpretation follows the flag.

## Operation
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - `req_rdy`=1, `resp_val`=0.
  - On `req_val`&`req_rdy`, latch the operands and go to CALC.
  - Magnitude handling:
    - signed=1: store |A| and |B| as unsigned values, and latch neg = A[msb] ^ B[msb].
    - signed=0: neg=0.
    - |−2^(nbits−1)| = 2^(nbits−1) fits in nbits unsigned bits; no overflow case exists.
  - On entry to CALC:
    - a_reg (2*nbits) = zero-extended |A|;
    - b_reg (nbits) = |B|;
    - result_reg (2*nbits) = 0.
- CALC, one step per cycle:
  - if b_reg[0], result_reg += a_reg (modulo 2^(2*nbits));
  - a_reg <<= 1;
  - b_reg >>= 1.
  - Exit to DONE when the shifted b_reg equals 0.
  - The first CALC cycle always executes, so B=0 spends exactly 1 CALC cycle.
  - CALC cycles = max(1, index of highest set bit of |B| + 1); maximum nbits.
- DONE:
  - `resp_val`=1.
  - `resp_msg` = neg ? (~result_reg + 1) : result_reg, taken modulo 2^(2*nbits).
  - Hold `resp_msg` stable until `resp_rdy`; on `resp_rdy`, go to IDLE.
- `req_rdy` is asserted only in IDLE. A response handshake and a new request acceptance never occur in the same cycle.
- Handshake outputs depend only on the FSM state. There is no combinational path from `req_val` or `resp_rdy` to any output.

## Timing
- Reset:
  - While `reset` is high: state←IDLE, all datapath registers←0, neg←0.
  - Outputs during a reset cycle: `req_rdy`=0, `resp_val`=0, `resp_msg`=0.
  - In the first cycle after `reset` deasserts: `req_rdy`=1.
- Reset asserted in CALC or DONE aborts the operation. The in-flight response is discarded and never presented.
- Latency: request handshake in cycle t; CALC occupies cycles t+1 … t+k; `resp_val` first goes high in cycle t+k+1.
  - k = CALC cycle count from Operation.
  - Minimum latency 2 cycles (B=0 or |B|=1); maximum nbits+1.
- Throughput: at most one request per k+2 cycles, counting the IDLE cycle.
- Backpressure: with `resp_rdy`=0, DONE holds indefinitely. `resp_msg` and `resp_val` stay constant, and `req_rdy` stays 0.
- `req_msg` is sampled only on the acceptance edge. Changes to it afterwards have no effect.

## Test plan
- Basic unsigned, nbits=32, A=3, B=4, signed=0:
  - `resp_msg`=0x0000000000000000C;
  - `resp_val` rises 4 cycles after acceptance (3 CALC cycles).
- Zero B, A=0xDEADBEEF, B=0, signed=0:
  - `resp_msg`=0;
  - `resp_val` 2 cycles after acceptance.
- Signed mode:
  - A=−3 (0xFFFFFFFD), B=5, signed=1: `resp_msg`=0xFFFFFFFFFFFFFFF1, latency 4.
  - A=0x80000000, B=0x80000000, signed=1: `resp_msg`=0x4000000000000000, latency 33.
- Unsigned maximum, A=B=0xFFFFFFFF, signed=0:
  - `resp_msg`=0xFFFFFFFE00000001;
  - latency 33.
  - Repeat with signed=1: `resp_msg`=1.
- Backpressure and reset:
  - Hold `resp_rdy`=0 for 10 cycles in DONE: `resp_msg` stable, `req_rdy`=0 throughout.
  - Then assert `reset` mid-CALC of a second request: the next cycle is IDLE, `req_rdy`=1, and no response is ever produced for the aborted request.
- Parameter sweep, nbits=8, random signed and unsigned operands with random `req_val`/`resp_rdy` stalls:
  - every `resp_msg` matches the 16-bit reference product;
  - every latency equals k+1.
